// File: rtl/spart_ctrl_if.sv
// spart_ctrl_if: SPART control/handshake signals between the controller and the SPART
interface spart_ctrl_if;
  logic iocs;
  logic iorw;
  logic [1:0] ioaddr;
  logic rda;
  logic tbr;
  modport master(output iocs, iorw, ioaddr, input rda, tbr);
  modport slave(input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_ctrl.sv
// spart_ctrl: programs the SPART baud divisor and echoes received bytes through a small FIFO
module spart_ctrl #(
  parameter logic [15:0] DIV_4800 = 16'h028A,
  parameter logic [15:0] DIV_9600 = 16'h0145,
  parameter logic [15:0] DIV_19200 = 16'h00A2,
  parameter logic [15:0] DIV_38400 = 16'h0050,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  input logic [1:0] br_cfg,
  spart_ctrl_if.master bus,
  inout wire [7:0] databus,
  output logic [7:0] byte_count,
  output logic cfg_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RX_RD, TX_WR, GAP} state_t;
  state_t state, state_nxt;
  logic [1:0] cfg_q;
  logic [7:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [15:0] div;
  logic [7:0] dout;
  logic reconf, full, empty, drive;
  assign div = cfg_q == 2'b00 ? DIV_4800 : cfg_q == 2'b01 ? DIV_9600 : cfg_q == 2'b10 ? DIV_19200 : DIV_38400;
  assign full = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign reconf = state == IDLE && br_cfg != cfg_q;
  // Bus outputs decode from state and are forced inactive while reset is asserted
  always_comb begin
    drive = rst && (state == CFG_LO || state == CFG_HI || state == TX_WR);
    bus.iocs = drive || (rst && state == RX_RD);
    bus.iorw = !drive;
    bus.ioaddr = !rst ? 2'b00 : state == CFG_LO ? 2'b10 : state == CFG_HI ? 2'b11 : 2'b00;
    dout = state == CFG_LO ? div[7:0] : state == CFG_HI ? div[15:8] : fifo[rd_ptr];
  end
  assign databus = drive ? dout : 8'hzz;
  // Next state: every access is followed by a GAP; IDLE prefers reconfig, then receive, then transmit
  always_comb begin
    case (state)
      CFG_LO: state_nxt = CFG_HI;
      CFG_HI, RX_RD, TX_WR: state_nxt = GAP;
      GAP: state_nxt = IDLE;
      default: state_nxt = reconf ? CFG_LO : (bus.rda && !full) ? RX_RD : (bus.tbr && !empty) ? TX_WR : IDLE;
    endcase
  end
  // State register, divisor selection, echo FIFO and byte counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= CFG_LO;
      cfg_q <= br_cfg;
      cfg_done <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      byte_count <= 8'd0;
    end else begin
      state <= state_nxt;
      if (reconf) begin
        cfg_q <= br_cfg;
        cfg_done <= 1'b0;
      end
      if (state == CFG_HI) cfg_done <= 1'b1;
      if (state == RX_RD) begin
        fifo[wr_ptr] <= databus;
        wr_ptr <= wr_ptr + 1'b1;
        count <= count + 1'b1;
      end
      if (state == TX_WR) begin
        rd_ptr <= rd_ptr + 1'b1;
        count <= count - 1'b1;
        byte_count <= byte_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_spart_ctrl.sv
// tb_spart_ctrl: scoreboard bench for spart_ctrl with a reactive SPART model
module tb_spart_ctrl;
  typedef struct {
    logic [1:0] cfg;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] data;
  } cfg_vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  wire [7:0] databus;
  logic [7:0] byte_count;
  logic cfg_done;
  logic [7:0] sp_head = 8'h00;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [9:0] cfg_log[$];
  int tests = 0, fails = 0, nrd = 0, ntx = 0, viol = 0, kind = 0, sent = 0, base = 0;
  logic prev_iocs = 1'b0;
  logic [1:0] prev_addr = 2'b00;
  logic found;
  cfg_vec_t tab[4];

  spart_ctrl_if bus();
  spart_ctrl dut(.clk(clk), .rst(rst), .br_cfg(br_cfg), .bus(bus), .databus(databus),
                 .byte_count(byte_count), .cfg_done(cfg_done));

  always #5 clk = ~clk;
  pullup (databus);
  assign databus = (bus.iocs && bus.iorw && bus.ioaddr == 2'b00 && bus.rda) ? sp_head : 8'hzz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sync_rx();
    bus.rda = rx_q.size() != 0;
    sp_head = rx_q.size() != 0 ? rx_q[0] : 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
    exp_q.push_back(b);
    sent++;
    sync_rx();
  endtask

  task automatic cyc();
    logic rd;
    @(negedge clk);
    kind = 0;
    rd = bus.iocs && bus.iorw && bus.ioaddr == 2'b00;
    if (rd) begin
      kind = 1;
      nrd++;
    end
    if (bus.iocs && !bus.iorw) begin
      if (bus.ioaddr == 2'b00) begin
        kind = 2;
        ntx++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_unexpected: got write %0h expected no write", databus);
        end else chk("tx_data", 32'(databus), 32'(exp_q.pop_front()));
      end else begin
        kind = 3;
        cfg_log.push_back({bus.ioaddr, databus});
      end
    end
    if (bus.iocs && prev_iocs && !(prev_addr == 2'b10 && bus.ioaddr == 2'b11)) viol++;
    prev_iocs = bus.iocs;
    prev_addr = bus.ioaddr;
    @(posedge clk);
    #1;
    if (rd && rx_q.size() != 0) rx_q.delete(0);
    sync_rx();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc();
    run(2);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [9:0] log_at(input int i);
    return cfg_log.size() > i ? cfg_log[i] : 10'h3FF;
  endfunction

  initial begin
    tab[0] = '{2'b00, 8'h8A, 8'h02, 8'hC1};
    tab[1] = '{2'b01, 8'h45, 8'h01, 8'hC2};
    tab[2] = '{2'b10, 8'hA2, 8'h00, 8'hC3};
    tab[3] = '{2'b11, 8'h50, 8'h00, 8'hC4};
    bus.rda = 1'b0;
    bus.tbr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_iocs", 32'(bus.iocs), 0);
    chk("rst_iorw", 32'(bus.iorw), 1);
    chk("rst_ioaddr", 32'(bus.ioaddr), 0);
    chk("rst_bus_z", 32'(databus), 32'hFF);
    chk("rst_byte_count", 32'(byte_count), 0);
    chk("rst_cfg_done", 32'(cfg_done), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc();
    chk("cfg_done_early", 32'(cfg_done), 0);
    cyc();
    chk("boot_lo", 32'(log_at(0)), 32'({2'b10, 8'h45}));
    chk("boot_hi", 32'(log_at(1)), 32'({2'b11, 8'h01}));
    chk("boot_cfg_done", 32'(cfg_done), 1);
    run(2);
    chk("idle_bus_z", 32'(databus), 32'hFF);

    base = nrd;
    bus.tbr = 1'b1;
    send(8'h5A);
    drain(30);
    chk("echo_count", 32'(byte_count), 32'(sent));
    chk("echo_reads", nrd - base, 1);

    base = nrd;
    bus.tbr = 1'b0;
    for (int b = 1; b <= 5; b++) send(8'(b));
    run(40);
    chk("burst_reads_full", nrd - base, 4);
    chk("burst_rda_held", 32'(bus.rda), 1);
    bus.tbr = 1'b1;
    drain(80);
    chk("burst_reads_all", nrd - base, 5);
    chk("burst_count", 32'(byte_count), 32'(sent));

    base = nrd;
    bus.tbr = 1'b0;
    send(8'h11);
    for (int i = 0; i < 20 && nrd == base; i++) cyc();
    run(3);
    send(8'h22);
    bus.tbr = 1'b1;
    kind = 0;
    for (int i = 0; i < 10 && kind == 0; i++) cyc();
    chk("prio_rx_first", kind, 1);
    drain(40);
    chk("prio_count", 32'(byte_count), 32'(sent));

    base = nrd;
    bus.tbr = 1'b0;
    send(8'h33);
    send(8'h44);
    run(20);
    chk("recfg_buffered", nrd - base, 2);
    br_cfg = 2'b11;
    cfg_log.delete();
    cyc();
    chk("recfg_done_drop", 32'(cfg_done), 0);
    run(3);
    chk("recfg_lo", 32'(log_at(0)), 32'({2'b10, 8'h50}));
    chk("recfg_hi", 32'(log_at(1)), 32'({2'b11, 8'h00}));
    chk("recfg_done", 32'(cfg_done), 1);
    bus.tbr = 1'b1;
    drain(40);
    chk("recfg_count", 32'(byte_count), 32'(sent));

    for (int t = 0; t < 4; t++) begin
      br_cfg = tab[t].cfg;
      cfg_log.delete();
      send(tab[t].data);
      run(4);
      chk("tab_lo", 32'(log_at(0)), 32'({2'b10, tab[t].lo}));
      chk("tab_hi", 32'(log_at(1)), 32'({2'b11, tab[t].hi}));
      chk("tab_cfg_done", 32'(cfg_done), 1);
      drain(30);
      chk("tab_count", 32'(byte_count), 32'(sent));
    end

    base = 255 - sent;
    for (int i = 0; i < base; i++) send(8'(i));
    drain(base * 10 + 50);
    chk("count_255", 32'(byte_count), 32'hFF);
    send(8'hE1);
    send(8'hE2);
    drain(40);
    chk("count_wrap", 32'(byte_count), 32'h01);

    bus.tbr = 1'b0;
    send(8'h66);
    send(8'h77);
    run(20);
    bus.tbr = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus.iocs && !bus.iorw && bus.ioaddr == 2'b00;
      if (!found) begin
        @(posedge clk);
        #1;
      end
    end
    chk("tx_found", 32'(found), 1);
    chk("tx_before_rst", 32'(databus), 32'h66);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_iocs", 32'(bus.iocs), 0);
    chk("midrst_bus_z", 32'(databus), 32'hFF);
    chk("midrst_count", 32'(byte_count), 0);
    chk("midrst_cfg_done", 32'(cfg_done), 0);
    exp_q.delete();
    prev_iocs = 1'b0;
    br_cfg = 2'b10;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cfg_log.delete();
    base = ntx;
    cyc();
    chk("post_rst_cfg_first", 32'(log_at(0)), 32'({2'b10, 8'hA2}));
    run(20);
    chk("post_rst_no_tx", ntx - base, 0);
    chk("post_rst_count", 32'(byte_count), 0);
    chk("iocs_spacing", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
